// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the program counter, fetches one 16-bit word
// at a time from instruction memory over a req/ack handshake, and holds it in
// IR until the controller takes it. Redirects restart fetch at a new address,
// and a redirect that arrives while a read is in flight drops that read's data.
module instr_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] IR,
  output logic        ir_valid,
  input  logic        ir_take,
  output logic [15:0] pc,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] fetch_count
);

  // IDLE only follows reset; DISCARD waits out a read whose data is stale.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } state_t;

  state_t      state_q,    state_next;
  logic [15:0] fetch_pc_q, fetch_pc_next;
  logic [15:0] target_q,   target_next;
  logic [15:0] ir_q,       ir_next;
  logic        valid_q,    valid_next;
  logic [15:0] pc_q,       pc_next;
  logic [15:0] count_q,    count_next;

  // Register all fetch state; reset returns to IDLE mid-request as well.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      target_q   <= RESET_PC;
      ir_q       <= 16'h0000;
      valid_q    <= 1'b0;
      pc_q       <= RESET_PC;
      count_q    <= 16'h0000;
    end else begin
      state_q    <= state_next;
      fetch_pc_q <= fetch_pc_next;
      target_q   <= target_next;
      ir_q       <= ir_next;
      valid_q    <= valid_next;
      pc_q       <= pc_next;
      count_q    <= count_next;
    end
  end

  // Next-state and next-datapath decode; redirect outranks ack data and take.
  // NOTE: every variable gets its hold value first so no path can infer a latch.
  always_comb begin
    state_next    = state_q;
    fetch_pc_next = fetch_pc_q;
    target_next   = target_q;
    ir_next       = ir_q;
    valid_next    = valid_q;
    pc_next       = pc_q;
    count_next    = count_q;

    unique case (state_q)
      IDLE: begin
        if (redirect) fetch_pc_next = redirect_pc;
        state_next = REQ;
      end

      REQ: begin
        if (redirect) begin
          if (imem_ack) begin
            // Returned word belongs to the old stream; go straight to the target.
            fetch_pc_next = redirect_pc;
            state_next    = REQ;
          end else begin
            // Read still in flight: park the target and wait for its ack.
            target_next = redirect_pc;
            state_next  = DISCARD;
          end
        end else if (imem_ack) begin
          ir_next       = imem_rdata;
          pc_next       = fetch_pc_q;
          fetch_pc_next = fetch_pc_q + 16'd1;
          valid_next    = 1'b1;
          state_next    = HOLD;
        end
      end

      HOLD: begin
        // A take in the same cycle as a redirect is still a consumed instruction.
        if (ir_take) count_next = count_q + 16'd1;
        if (redirect) begin
          valid_next    = 1'b0;
          fetch_pc_next = redirect_pc;
          state_next    = REQ;
        end else if (ir_take) begin
          valid_next = 1'b0;
          state_next = REQ;
        end
      end

      DISCARD: begin
        if (redirect) target_next = redirect_pc;
        if (imem_ack) begin
          // The newest redirect wins even if it lands on the ack cycle.
          fetch_pc_next = redirect ? redirect_pc : target_q;
          state_next    = REQ;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // Outputs come straight from registers or from the state decode.
  assign imem_req    = (state_q == REQ) || (state_q == DISCARD);
  assign imem_addr   = fetch_pc_q;
  assign IR          = ir_q;
  assign ir_valid    = valid_q;
  assign pc          = pc_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a table of per-cycle input/expected-output
// records, followed by hand-written sequences for counter wrap and reset
// during an outstanding request.
module tb_instr_fetch;

  localparam logic [15:0] RPC = 16'h0010;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic [15:0] IR;
  logic        ir_valid;
  logic        ir_take = 1'b0;
  logic [15:0] pc;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic [15:0] fetch_count;

  int tests_run = 0;
  int tests_failed = 0;

  instr_fetch #(.RESET_PC(RPC)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .IR          (IR),
    .ir_valid    (ir_valid),
    .ir_take     (ir_take),
    .pc          (pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fetch_count (fetch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ack;
    logic [15:0] rdata;
    logic        take;
    logic        redir;
    logic [15:0] rpc;
    logic        e_req;
    logic [15:0] e_addr;
    logic [15:0] e_ir;
    logic        e_valid;
    logic [15:0] e_pc;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic rst, logic ack, logic [15:0] rdata,
                              logic take, logic redir, logic [15:0] rpc,
                              logic e_req, logic [15:0] e_addr, logic [15:0] e_ir,
                              logic e_valid, logic [15:0] e_pc, logic [15:0] e_cnt);
    vec_t v;
    v.rst = rst; v.ack = ack; v.rdata = rdata; v.take = take;
    v.redir = redir; v.rpc = rpc; v.e_req = e_req; v.e_addr = e_addr;
    v.e_ir = e_ir; v.e_valid = e_valid; v.e_pc = e_pc; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic e_req, input logic [15:0] e_addr,
                           input logic [15:0] e_ir, input logic e_valid,
                           input logic [15:0] e_pc, input logic [15:0] e_cnt);
    check({tag, " imem_req"},    {15'd0, imem_req}, {15'd0, e_req});
    check({tag, " imem_addr"},   imem_addr,         e_addr);
    check({tag, " IR"},          IR,                e_ir);
    check({tag, " ir_valid"},    {15'd0, ir_valid}, {15'd0, e_valid});
    check({tag, " pc"},          pc,                e_pc);
    check({tag, " fetch_count"}, fetch_count,       e_cnt);
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Rows: rst ack rdata take redir rpc | req addr IR valid pc count
    vq.push_back(mk(0,0,16'h0000,0,0,16'h0000, 1,16'h0010,16'h0000,0,16'h0010,16'd0)); // 0 IDLE->REQ
    vq.push_back(mk(0,1,16'h1234,0,0,16'h0000, 0,16'h0011,16'h1234,1,16'h0010,16'd0)); // 1 zero-wait ack
    vq.push_back(mk(0,0,16'h0000,0,0,16'h0000, 0,16'h0011,16'h1234,1,16'h0010,16'd0)); // 2 hold
    vq.push_back(mk(0,0,16'h0000,1,0,16'h0000, 1,16'h0011,16'h1234,0,16'h0010,16'd1)); // 3 take
    vq.push_back(mk(0,0,16'h0000,0,0,16'h0000, 1,16'h0011,16'h1234,0,16'h0010,16'd1)); // 4 wait
    vq.push_back(mk(0,0,16'h0000,0,0,16'h0000, 1,16'h0011,16'h1234,0,16'h0010,16'd1)); // 5 wait
    vq.push_back(mk(0,0,16'h0000,0,0,16'h0000, 1,16'h0011,16'h1234,0,16'h0010,16'd1)); // 6 wait
    vq.push_back(mk(0,1,16'hABCD,0,0,16'h0000, 0,16'h0012,16'hABCD,1,16'h0011,16'd1)); // 7 ack
    vq.push_back(mk(0,1,16'hFFFF,0,0,16'h0000, 0,16'h0012,16'hABCD,1,16'h0011,16'd1)); // 8 ack w/o req
    vq.push_back(mk(0,0,16'h0000,1,0,16'h0000, 1,16'h0012,16'hABCD,0,16'h0011,16'd2)); // 9 take
    vq.push_back(mk(0,0,16'h0000,1,0,16'h0000, 1,16'h0012,16'hABCD,0,16'h0011,16'd2)); // 10 take ignored
    vq.push_back(mk(0,1,16'h5555,0,0,16'h0000, 0,16'h0013,16'h5555,1,16'h0012,16'd2)); // 11 ack
    vq.push_back(mk(0,0,16'h0000,1,1,16'h0040, 1,16'h0040,16'h5555,0,16'h0012,16'd3)); // 12 redir+take in HOLD
    vq.push_back(mk(0,1,16'h6666,0,1,16'h0050, 1,16'h0050,16'h5555,0,16'h0012,16'd3)); // 13 redir+ack in REQ
    vq.push_back(mk(0,0,16'h0000,0,1,16'h0005, 1,16'h0050,16'h5555,0,16'h0012,16'd3)); // 14 redir no ack
    vq.push_back(mk(0,1,16'h7777,0,0,16'h0000, 1,16'h0005,16'h5555,0,16'h0012,16'd3)); // 15 discard ack
    vq.push_back(mk(0,0,16'h0000,0,1,16'h0080, 1,16'h0005,16'h5555,0,16'h0012,16'd3)); // 16 redir 0080
    vq.push_back(mk(0,0,16'h0000,0,1,16'h0090, 1,16'h0005,16'h5555,0,16'h0012,16'd3)); // 17 redir 0090
    vq.push_back(mk(0,0,16'h0000,0,0,16'h0000, 1,16'h0005,16'h5555,0,16'h0012,16'd3)); // 18 wait
    vq.push_back(mk(0,1,16'h8888,0,0,16'h0000, 1,16'h0090,16'h5555,0,16'h0012,16'd3)); // 19 dropped ack
    vq.push_back(mk(0,1,16'h9999,0,0,16'h0000, 0,16'h0091,16'h9999,1,16'h0090,16'd3)); // 20 ack
    vq.push_back(mk(0,0,16'h0000,0,1,16'hFFFF, 1,16'hFFFF,16'h9999,0,16'h0090,16'd3)); // 21 redir FFFF
    vq.push_back(mk(0,1,16'hAAAA,0,0,16'h0000, 0,16'h0000,16'hAAAA,1,16'hFFFF,16'd3)); // 22 pc wraps
    vq.push_back(mk(0,0,16'h0000,1,0,16'h0000, 1,16'h0000,16'hAAAA,0,16'hFFFF,16'd4)); // 23 take
    vq.push_back(mk(0,1,16'hBBBB,0,0,16'h0000, 0,16'h0001,16'hBBBB,1,16'h0000,16'd4)); // 24 ack

    // Asynchronous reset assertion and reset-state check.
    #1 reset = 1'b1;
    #2 check_all("reset", 1'b0, RPC, 16'h0000, 1'b0, RPC, 16'd0);

    // Table-driven section: drive on the falling edge, sample 1 after rising.
    foreach (vq[i]) begin
      @(negedge clk);
      reset       = vq[i].rst;
      imem_ack    = vq[i].ack;
      imem_rdata  = vq[i].rdata;
      ir_take     = vq[i].take;
      redirect    = vq[i].redir;
      redirect_pc = vq[i].rpc;
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vq[i].e_req, vq[i].e_addr, vq[i].e_ir,
                vq[i].e_valid, vq[i].e_pc, vq[i].e_cnt);
    end

    // fetch_count wrap: preload the counter to FFFF, then one take.
    @(negedge clk);
    imem_ack = 1'b0; ir_take = 1'b0; redirect = 1'b0;
    force dut.count_next = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.count_next;
    check("preload fetch_count", fetch_count, 16'hFFFF);
    @(negedge clk);
    ir_take = 1'b1;
    @(posedge clk);
    #1;
    check("wrap fetch_count", fetch_count, 16'h0000);
    check("wrap imem_addr", imem_addr, 16'h0001);
    check("wrap imem_req", {15'd0, imem_req}, 16'd1);

    // Reset in the middle of a wait-state request, with stale acks.
    @(negedge clk);
    ir_take = 1'b0;
    @(posedge clk);
    #1;
    check("pre-reset imem_req", {15'd0, imem_req}, 16'd1);
    #2 reset = 1'b1;
    #1 check_all("async reset", 1'b0, RPC, 16'h0000, 1'b0, RPC, 16'd0);
    @(negedge clk);
    imem_ack = 1'b1; imem_rdata = 16'hDEAD;
    @(posedge clk);
    #1;
    check_all("ack in reset", 1'b0, RPC, 16'h0000, 1'b0, RPC, 16'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_all("ack after release", 1'b1, RPC, 16'h0000, 1'b0, RPC, 16'd0);
    @(negedge clk);
    imem_rdata = 16'h1234;
    @(posedge clk);
    #1;
    check_all("refetch", 1'b0, RPC + 16'd1, 16'h1234, 1'b1, RPC, 16'd0);

    @(negedge clk);
    imem_ack = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
